multi_cycle_ctrl: RTL

- Multi-cycle MIPS control unit sitting directly upstream of the CPU datapath; drives every datapath mux/enable (ALUSrc_A, ALUSrc_B, ALU_Control, Branch, DatatoReg, RegDst, RegWrite, PCEN).
- Also sequences instruction fetch and data access over the shared memory/IO bus (MemRead, MemWrite, IRWrite) with a MIO_ready handshake.
- Decodes OPcode/Fun from the instruction register and zero from the ALU.
- PC advances exactly once per instruction, in its final state.

---
 rtl/multi_cycle_ctrl.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multi_cycle_ctrl
//  Description : Multi-cycle MIPS control unit. Sequences fetch, decode,
//                execute, memory and write-back states, drives every datapath
//                mux/enable and handshakes the shared memory/IO bus through
//                MIO_ready. Optional wait timeout abandons a stalled transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_ctrl #(
    parameter int TIMEOUT_EN = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] OPcode,
    input  logic [5:0] Fun,
    input  logic       zero,
    input  logic       MIO_ready,
    output logic       ALUSrc_A,
    output logic       ALUSrc_B,
    output logic [2:0] ALU_Control,
    output logic [1:0] Branch,
    output logic [1:0] DatatoReg,
    output logic [1:0] RegDst,
    output logic       RegWrite,
    output logic       PCEN,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       CPU_MIO,
    output logic [3:0] state
);

    // State encoding (visible on the debug port)
    localparam logic [3:0] c_ST_IF   = 4'd0;
    localparam logic [3:0] c_ST_ID   = 4'd1;
    localparam logic [3:0] c_ST_MA   = 4'd2;
    localparam logic [3:0] c_ST_LR   = 4'd3;
    localparam logic [3:0] c_ST_LW   = 4'd4;
    localparam logic [3:0] c_ST_SW   = 4'd5;
    localparam logic [3:0] c_ST_REX  = 4'd6;
    localparam logic [3:0] c_ST_RWB  = 4'd7;
    localparam logic [3:0] c_ST_IEX  = 4'd8;
    localparam logic [3:0] c_ST_IWB  = 4'd9;
    localparam logic [3:0] c_ST_BR   = 4'd10;
    localparam logic [3:0] c_ST_J    = 4'd11;
    localparam logic [3:0] c_ST_JAL  = 4'd12;
    localparam logic [3:0] c_ST_JR   = 4'd13;
    localparam logic [3:0] c_ST_LUI  = 4'd14;
    localparam logic [3:0] c_ST_ILL  = 4'd15;

    // Opcodes
    localparam logic [5:0] c_OP_R    = 6'b000000;
    localparam logic [5:0] c_OP_LW   = 6'b100011;
    localparam logic [5:0] c_OP_SW   = 6'b101011;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_BNE  = 6'b000101;
    localparam logic [5:0] c_OP_J    = 6'b000010;
    localparam logic [5:0] c_OP_JAL  = 6'b000011;
    localparam logic [5:0] c_OP_LUI  = 6'b001111;
    localparam logic [5:0] c_OP_ADDI = 6'b001000;
    localparam logic [5:0] c_OP_SLTI = 6'b001010;
    localparam logic [5:0] c_OP_ANDI = 6'b001100;
    localparam logic [5:0] c_OP_ORI  = 6'b001101;
    localparam logic [5:0] c_OP_XORI = 6'b001110;

    // R-type function codes
    localparam logic [5:0] c_FN_ADD  = 6'b100000;
    localparam logic [5:0] c_FN_SUB  = 6'b100010;
    localparam logic [5:0] c_FN_AND  = 6'b100100;
    localparam logic [5:0] c_FN_OR   = 6'b100101;
    localparam logic [5:0] c_FN_XOR  = 6'b100110;
    localparam logic [5:0] c_FN_NOR  = 6'b100111;
    localparam logic [5:0] c_FN_SLT  = 6'b101010;
    localparam logic [5:0] c_FN_SRL  = 6'b000010;
    localparam logic [5:0] c_FN_JR   = 6'b001000;

    // ALU operation codes
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_XOR = 3'b011;
    localparam logic [2:0] c_ALU_NOR = 3'b100;
    localparam logic [2:0] c_ALU_SRL = 3'b101;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    localparam logic [7:0] c_WAIT_MAX = 8'd255;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [2:0] w_r_alu;
    logic [2:0] w_i_alu;
    logic       w_fun_ok;
    logic       w_br_taken;
    logic       w_timeout;

    assign state = r_state;

    // R-type funct decode: ALU operation and whether the funct is supported
    always_comb begin
        w_r_alu  = c_ALU_AND;
        w_fun_ok = 1'b1;
        case (Fun)
            c_FN_ADD: w_r_alu = c_ALU_ADD;
            c_FN_SUB: w_r_alu = c_ALU_SUB;
            c_FN_AND: w_r_alu = c_ALU_AND;
            c_FN_OR:  w_r_alu = c_ALU_OR;
            c_FN_XOR: w_r_alu = c_ALU_XOR;
            c_FN_NOR: w_r_alu = c_ALU_NOR;
            c_FN_SLT: w_r_alu = c_ALU_SLT;
            c_FN_SRL: w_r_alu = c_ALU_SRL;
            default:  w_fun_ok = 1'b0;
        endcase
    end

    // I-type opcode to ALU operation
    always_comb begin
        w_i_alu = c_ALU_AND;
        case (OPcode)
            c_OP_ADDI: w_i_alu = c_ALU_ADD;
            c_OP_SLTI: w_i_alu = c_ALU_SLT;
            c_OP_ANDI: w_i_alu = c_ALU_AND;
            c_OP_ORI:  w_i_alu = c_ALU_OR;
            c_OP_XORI: w_i_alu = c_ALU_XOR;
            default:   w_i_alu = c_ALU_AND;
        endcase
    end

    assign w_br_taken = ((OPcode == c_OP_BEQ) &&  zero) ||
                        ((OPcode == c_OP_BNE) && !zero);

    generate
        if (TIMEOUT_EN != 0) begin : g_timeout
            logic [7:0] r_wait_cnt;
            logic       w_waiting;

            assign w_waiting = ((r_state == c_ST_IF) || (r_state == c_ST_LR) ||
                                (r_state == c_ST_SW)) && !MIO_ready;
            assign w_timeout = w_waiting && (r_wait_cnt == c_WAIT_MAX);

            // Wait counter: cleared on every state entry (a timeout re-enters IF)
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_wait_cnt <= 8'd0;
                end else if ((w_next != r_state) || w_timeout) begin
                    r_wait_cnt <= 8'd0;
                end else if (w_waiting) begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end
            end
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // Next-state selection; a timeout overrides and returns to fetch
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IF:  if (MIO_ready) w_next = c_ST_ID;
            c_ST_ID: begin
                case (OPcode)
                    c_OP_R: begin
                        if (Fun == c_FN_JR)  w_next = c_ST_JR;
                        else if (w_fun_ok)   w_next = c_ST_REX;
                        else                 w_next = c_ST_ILL;
                    end
                    c_OP_LW, c_OP_SW:   w_next = c_ST_MA;
                    c_OP_BEQ, c_OP_BNE: w_next = c_ST_BR;
                    c_OP_J:             w_next = c_ST_J;
                    c_OP_JAL:           w_next = c_ST_JAL;
                    c_OP_LUI:           w_next = c_ST_LUI;
                    c_OP_ADDI, c_OP_SLTI, c_OP_ANDI, c_OP_ORI, c_OP_XORI:
                                        w_next = c_ST_IEX;
                    default:            w_next = c_ST_ILL;
                endcase
            end
            c_ST_MA:  w_next = (OPcode == c_OP_LW) ? c_ST_LR : c_ST_SW;
            c_ST_LR:  if (MIO_ready) w_next = c_ST_LW;
            c_ST_SW:  if (MIO_ready) w_next = c_ST_IF;
            c_ST_REX: w_next = c_ST_RWB;
            c_ST_IEX: w_next = c_ST_IWB;
            default:  w_next = c_ST_IF;
        endcase
        if (w_timeout) w_next = c_ST_IF;
    end

    // State register; reset lands in fetch at any point of an instruction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= c_ST_IF;
        else      r_state <= w_next;
    end

    // Datapath controls decoded from the current state and instruction fields
    always_comb begin
        ALUSrc_A    = 1'b0;
        ALUSrc_B    = 1'b0;
        ALU_Control = c_ALU_AND;
        Branch      = 2'b00;
        DatatoReg   = 2'b00;
        RegDst      = 2'b00;
        RegWrite    = 1'b0;
        PCEN        = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        case (r_state)
            c_ST_IF: begin
                MemRead = 1'b1;
                IRWrite = MIO_ready;
            end
            c_ST_REX, c_ST_RWB: begin
                ALUSrc_A    = (Fun == c_FN_SRL);
                ALU_Control = w_r_alu;
                if (r_state == c_ST_RWB) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b01;
                    PCEN     = 1'b1;
                end
            end
            c_ST_IEX, c_ST_IWB: begin
                ALUSrc_B    = 1'b1;
                ALU_Control = w_i_alu;
                if (r_state == c_ST_IWB) begin
                    RegWrite = 1'b1;
                    PCEN     = 1'b1;
                end
            end
            c_ST_MA, c_ST_LR, c_ST_LW, c_ST_SW: begin
                // Address computation held steady through the whole access
                ALUSrc_B    = 1'b1;
                ALU_Control = c_ALU_ADD;
                if (r_state == c_ST_LR) MemRead = 1'b1;
                if (r_state == c_ST_LW) begin
                    RegWrite  = 1'b1;
                    DatatoReg = 2'b01;
                    PCEN      = 1'b1;
                end
                if (r_state == c_ST_SW) begin
                    MemWrite = 1'b1;
                    PCEN     = MIO_ready;
                end
            end
            c_ST_BR: begin
                ALU_Control = c_ALU_SUB;
                PCEN        = 1'b1;
                Branch      = w_br_taken ? 2'b01 : 2'b00;
            end
            c_ST_J: begin
                PCEN   = 1'b1;
                Branch = 2'b10;
            end
            c_ST_JAL: begin
                // Link captures pc+4 before the PC loads at this edge
                PCEN      = 1'b1;
                Branch    = 2'b10;
                RegWrite  = 1'b1;
                RegDst    = 2'b10;
                DatatoReg = 2'b11;
            end
            c_ST_JR: begin
                PCEN   = 1'b1;
                Branch = 2'b11;
            end
            c_ST_LUI: begin
                RegWrite  = 1'b1;
                DatatoReg = 2'b10;
                PCEN      = 1'b1;
            end
            c_ST_ILL: PCEN = 1'b1;
            default: ;
        endcase
        if (w_timeout) begin
            PCEN     = 1'b1;
            Branch   = 2'b00;
            RegWrite = 1'b0;
            IRWrite  = 1'b0;
        end
        CPU_MIO = MemRead | MemWrite;
    end

endmodule
`default_nettype wire
